// File: rtl/add_sub_chk_pkg.sv
// Shared types, default sizes and the golden add/sub function for the checker.
package add_sub_chk_pkg;

  localparam int unsigned W_DEF     = 4;
  localparam int unsigned N_VEC_DEF = 512;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Exact 5-bit result; subtract is a + ~b + ~cin so carry=1 means no borrow.
  function automatic logic [W_DEF:0] exp_add_sub(
    input logic [W_DEF-1:0] a,
    input logic [W_DEF-1:0] b,
    input logic             cin,
    input logic             op
  );
    logic [W_DEF:0] ea;
    logic [W_DEF:0] eb;
    logic [W_DEF:0] ec;
    ea = {1'b0, a};
    eb = op ? {1'b0, ~b} : {1'b0, b};
    ec = {{W_DEF{1'b0}}, (op ? ~cin : cin)};
    return ea + eb + ec;
  endfunction

endpackage

// File: rtl/add_sub_chk_ref_model.sv
// Combinational golden model used at the compare stage.
module add_sub_ref_model
  import add_sub_chk_pkg::*;
#(
  parameter int unsigned W = W_DEF
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  input  logic         op,
  output logic [W:0]   res
);

  // Pure function wrapper; no state.
  always_comb begin
    res = exp_add_sub(a, b, cin, op);
  end

endmodule

// File: rtl/add_sub_checker.sv
// Two-stage response checker: stage 1 samples vector + DUT result,
// stage 2 compares against the golden model and updates counters.
module add_sub_checker
  import add_sub_chk_pkg::*;
#(
  parameter int unsigned W     = W_DEF,
  parameter int unsigned N_VEC = N_VEC_DEF,
  parameter int unsigned CNT_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             vld_in,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic             cin,
  input  logic             add_sub,
  input  logic [W-1:0]     sum,
  input  logic             carry,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             first_fail,
  output logic [2*W+1:0]   ff_vec,
  output logic [W:0]       ff_got,
  output logic             busy,
  output logic             done,
  output logic             pass
);

  localparam logic [CNT_W-1:0] N_VEC_C = CNT_W'(N_VEC);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(N_VEC - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] vec_cnt;

  logic             s1_vld;
  logic [W-1:0]     s1_a;
  logic [W-1:0]     s1_b;
  logic             s1_cin;
  logic             s1_op;
  logic [W-1:0]     s1_sum;
  logic             s1_carry;

  logic [W:0]       exp_res;
  logic             capture;
  logic             arm;
  logic             mismatch;

  assign capture  = (state == CHECK) && vld_in && (vec_cnt < N_VEC_C);
  assign arm      = start && (state != CHECK);
  assign mismatch = ({s1_carry, s1_sum} != exp_res);

  add_sub_ref_model #(.W(W)) u_ref (
    .a   (s1_a),
    .b   (s1_b),
    .cin (s1_cin),
    .op  (s1_op),
    .res (exp_res)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: leave CHECK on the capture that makes vec_cnt reach N_VEC.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = CHECK;
      CHECK:   if (capture && (vec_cnt == LAST_C)) state_nxt = DONE;
      DONE:    if (start) state_nxt = CHECK;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs; done waits until the last in-flight compare has landed.
  always_comb begin
    busy = (state == CHECK);
    done = (state == DONE) && !s1_vld;
    pass = done && (fail_cnt == '0);
  end

  // Stage 1: sample vector and DUT result; count captured vectors.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld   <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_cin   <= 1'b0;
      s1_op    <= 1'b0;
      s1_sum   <= '0;
      s1_carry <= 1'b0;
      vec_cnt  <= '0;
    end else begin
      s1_vld <= capture;
      if (capture) begin
        s1_a     <= a;
        s1_b     <= b;
        s1_cin   <= cin;
        s1_op    <= add_sub;
        s1_sum   <= sum;
        s1_carry <= carry;
      end
      if (arm)          vec_cnt <= '0;
      else if (capture) vec_cnt <= vec_cnt + 1'b1;
    end
  end

  // Stage 2: compare, saturating counters, first-mismatch capture.
  // Arming a new run clears results and wins over a compare still in flight.
  always_ff @(posedge clk) begin
    if (rst || arm) begin
      pass_cnt   <= '0;
      fail_cnt   <= '0;
      first_fail <= 1'b0;
      ff_vec     <= '0;
      ff_got     <= '0;
    end else if (s1_vld) begin
      if (mismatch) begin
        if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
        if (!first_fail) begin
          first_fail <= 1'b1;
          ff_vec     <= {s1_op, s1_cin, s1_a, s1_b};
          ff_got     <= {s1_carry, s1_sum};
        end
      end else begin
        if (pass_cnt != '1) pass_cnt <= pass_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_add_sub_checker.sv
// Directed bench for add_sub_checker: full sweeps, injected errors,
// subtract boundaries, gaps/stray vectors, mid-run reset and restart.
module tb_add_sub_checker;

  localparam int unsigned W     = 4;
  localparam int unsigned N_VEC = 512;
  localparam int unsigned CNT_W = 10;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             vld_in;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic             cin;
  logic             add_sub;
  logic [W-1:0]     sum;
  logic             carry;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] fail_cnt;
  logic             first_fail;
  logic [2*W+1:0]   ff_vec;
  logic [W:0]       ff_got;
  logic             busy;
  logic             done;
  logic             pass;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  add_sub_checker #(.W(W), .N_VEC(N_VEC), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .vld_in     (vld_in),
    .a          (a),
    .b          (b),
    .cin        (cin),
    .add_sub    (add_sub),
    .sum        (sum),
    .carry      (carry),
    .pass_cnt   (pass_cnt),
    .fail_cnt   (fail_cnt),
    .first_fail (first_fail),
    .ff_vec     (ff_vec),
    .ff_got     (ff_got),
    .busy       (busy),
    .done       (done),
    .pass       (pass)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive sweep vector i as a golden DUT would answer it, optionally corrupting carry.
  task automatic drive_vec(input int i, input bit flip);
    int ia, ib, r;
    ia = (i >> 4) & 15;
    ib = i & 15;
    add_sub = (i >= 256);
    cin = 1'b0;
    a = ia[W-1:0];
    b = ib[W-1:0];
    if (add_sub) r = ia + (15 - ib) + 1;
    else         r = ia + ib;
    sum = r[W-1:0];
    carry = r[W] ^ flip;
    vld_in = 1'b1;
  endtask

  task automatic pulse_start(input bit stray);
    start = 1'b1;
    if (stray) drive_vec(5, 1'b1);
    tick();
    start = 1'b0;
    vld_in = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_pass_clr", 32'(pass_cnt), 32'd0);
    check("start_fail_clr", 32'(fail_cnt), 32'd0);
    check("start_ff_clr", 32'(first_fail), 32'd0);
  endtask

  task automatic run_sweep(input bit gap, input bit stray, input int e1, input int e2,
                           input int exp_fail);
    pulse_start(stray);
    for (int i = 0; i < int'(N_VEC); i++) begin
      drive_vec(i, (i == e1) || (i == e2));
      tick();
      if (gap && i != int'(N_VEC) - 1) begin
        vld_in = 1'b0;
        tick();
      end
    end
    vld_in = 1'b0;
    check("done_early", 32'(done), 32'd0);
    tick();
    check("done_rise", 32'(done), 32'd1);
    check("busy_end", 32'(busy), 32'd0);
    check("pass_cnt", 32'(pass_cnt), 32'(int'(N_VEC) - exp_fail));
    check("fail_cnt", 32'(fail_cnt), 32'(exp_fail));
    check("pass_flag", 32'(pass), 32'(exp_fail == 0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; vld_in = 1'b0; a = '0; b = '0;
    cin = 1'b0; add_sub = 1'b0; sum = '0; carry = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_pass_cnt", 32'(pass_cnt), 32'd0);
    check("rst_fail_cnt", 32'(fail_cnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ff_vec", 32'(ff_vec), 32'd0);

    // 1: clean full sweep
    run_sweep(1'b0, 1'b0, -1, -1, 0);
    check("t1_first_fail", 32'(first_fail), 32'd0);

    // 2: carry flipped on a=F,b=1,add (index 0xF1); restart from DONE
    run_sweep(1'b0, 1'b0, 241, -1, 1);
    check("t2_first_fail", 32'(first_fail), 32'd1);
    check("t2_ff_vec", 32'(ff_vec), 32'h0F1);
    check("t2_ff_got", 32'(ff_got), 32'h00);

    // 3: subtract boundaries with hand-computed results
    pulse_start(1'b0);
    add_sub = 1'b1;
    a = 4'h0; b = 4'h1; cin = 1'b0; {carry, sum} = 5'h0F; vld_in = 1'b1; tick();
    a = 4'h5; b = 4'h5; cin = 1'b1; {carry, sum} = 5'h0F; tick();
    a = 4'h5; b = 4'h3; cin = 1'b0; {carry, sum} = 5'h12; tick();
    vld_in = 1'b0;
    check("t3_latency", 32'(pass_cnt), 32'd2);
    tick();
    check("t3_pass_cnt", 32'(pass_cnt), 32'd3);
    check("t3_fail_cnt", 32'(fail_cnt), 32'd0);
    check("t3_busy", 32'(busy), 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;

    // 4: stray vld_in in IDLE, start+vld together, gapped sweep, stray after done
    for (int k = 0; k < 3; k++) begin
      drive_vec(k, 1'b1);
      tick();
    end
    vld_in = 1'b0;
    check("t4_idle_ignored", 32'(fail_cnt), 32'd0);
    run_sweep(1'b1, 1'b1, -1, -1, 0);
    for (int k = 0; k < 3; k++) begin
      drive_vec(k, 1'b1);
      tick();
    end
    vld_in = 1'b0;
    tick();
    check("t4_post_pass", 32'(pass_cnt), 32'd512);
    check("t4_post_fail", 32'(fail_cnt), 32'd0);
    check("t4_post_done", 32'(done), 32'd1);

    // 5: reset at vector 100, then a full sweep
    pulse_start(1'b0);
    for (int i = 0; i < 100; i++) begin
      drive_vec(i, (i == 7));
      tick();
    end
    rst = 1'b1;
    drive_vec(100, 1'b0);
    tick();
    rst = 1'b0;
    vld_in = 1'b0;
    check("t5_pass_cnt", 32'(pass_cnt), 32'd0);
    check("t5_fail_cnt", 32'(fail_cnt), 32'd0);
    check("t5_first_fail", 32'(first_fail), 32'd0);
    check("t5_ff_vec", 32'(ff_vec), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_done", 32'(done), 32'd0);
    check("t5_pass", 32'(pass), 32'd0);
    tick();
    check("t5_idle_hold", 32'(busy), 32'd0);
    run_sweep(1'b0, 1'b0, -1, -1, 0);

    // 6: restart from DONE with mismatches at index 10 and 300
    run_sweep(1'b0, 1'b0, 10, 300, 2);
    check("t6_first_fail", 32'(first_fail), 32'd1);
    check("t6_ff_vec", 32'(ff_vec), 32'h00A);
    check("t6_ff_got", 32'(ff_got), 32'h1A);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
